mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the multi-cycle CPU's memory port (Address/Write_data/MemRead/MemWrite/Mem_data).
- Serves a word-addressed data RAM and a small MMIO register window.
- Adds a configurable wait-state delay and a Mem_ready handshake, so the CPU controller can stall on slow memory.
- Sits between the CPU datapath and the board I/O (LEDs, 7-segment digits, optional timer).

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; RAM occupies byte addresses 0 to RAM_WORDS*4-1.
- WAIT_STATES, 2, extra cycles between request and response; legal range 0 to 15.
- MMIO_BASE, 32'h4000_0000, byte base address of the MMIO window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Address  in  32  byte address from the CPU.
- Write_data  in  32  store data.
- MemRead  in  1  read request; held high until Mem_ready.
- MemWrite  in  1  write request; held high until Mem_ready.
- Mem_data  out  32  read data; valid only while Mem_ready=1, otherwise 0.
- Mem_ready  out  1  one-cycle response strobe.
- Addr_err  out  1  valid with Mem_ready; 1 = misaligned, unmapped or conflicting request.
- leds  out  8  LED register.
- digits  out  12  7-segment register.
- irq  out  1  timer interrupt, sticky.

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: Mem_data=0, Mem_ready=0, Addr_err=0, leds=0, digits=0, irq=0; FSM goes to IDLE.
- Reset does not clear RAM contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is MemRead|MemWrite high at a rising edge.
  - On a request, latch Address, Write_data and direction, and load wcnt=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT:
  - Decrement wcnt each cycle; go to RESP when wcnt reaches 1.
  - Port inputs are ignored; latched values are used.
- RESP:
  - Mem_ready=1 for exactly one cycle; Mem_data and Addr_err are registered and valid in that cycle.
  - Next state is always IDLE.
- Latency: a request first high in cycle c gives Mem_ready in cycle c+WAIT_STATES+1.
- Writes commit on the edge entering RESP, so a read in the next transaction returns the new value.
- Requester rule: drop MemRead/MemWrite in the cycle after Mem_ready. A request still high in IDLE starts a new transaction. Back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- MemRead and MemWrite both high: treated as an error. Addr_err=1, no write, Mem_data=0.
- Decode, evaluated on the latched address:
  - Address[1:0]!=0: misaligned. Addr_err=1, no side effects, Mem_data=0.
  - Address < RAM_WORDS*4: RAM at word index Address[31:2]. Full 32-bit read/write.
  - MMIO_BASE+0x0: leds; write bits [7:0], read zero-extended.
  - MMIO_BASE+0x4: digits; write bits [11:0], read zero-extended.
  - MMIO_BASE+0x8 and +0xC: timer (see Optional Feature).
  - Any other address: unmapped. Addr_err=1, write dropped, Mem_data=0.
- Writes to read-only locations are ignored, Addr_err=0.
- Reset asserted in WAIT or RESP aborts the transaction:
  - A write not yet committed is discarded.
  - No Mem_ready is produced.
  - The FSM returns to IDLE.

Optional Feature:
- Macro: MEM_BUS_TIMER_EN.
- With the macro defined:
  - MMIO_BASE+0x8 is a 32-bit timer count (read-only).
  - MMIO_BASE+0xC is timer control: bit0 enable, bit1 irq_en, bit2 write-1-to-clear irq (reads as 0).
  - When enable=1, the count increments every cycle.
  - On wrap 32'hFFFF_FFFF→0 with irq_en=1, irq is set and stays 1 until cleared.
  - If a clear and a wrap happen in the same cycle, set wins.
  - Count and control reset to 0.
- Without the macro: +0x8 and +0xC are unmapped (Addr_err=1) and irq is tied to 0.

Test Plan:
- WAIT_STATES=2: write 32'hDEAD_BEEF to 0x10 in cycle 5, then read 0x10. Mem_ready in cycles 8 and 12; read Mem_data=32'hDEAD_BEEF, Addr_err=0.
- WAIT_STATES=0: read 0x0 after reset. Mem_ready exactly 1 cycle after request, single-cycle pulse.
- Write 32'h0000_01A5 to MMIO_BASE+0x0. leds=8'hA5 after Mem_ready; read back returns 32'h0000_00A5.
- Misaligned read 0x6, unmapped read MMIO_BASE+0x20, and MemRead=MemWrite=1 at 0x8. Each gives Addr_err=1, Mem_data=0, and RAM[2] is unchanged.
- Write 32'h1234 to 0x20; assert reset in the WAIT cycle; then read 0x20. No Mem_ready during the abort; read returns the old value.
- Timer (MEM_BUS_TIMER_EN defined): force the count to 32'hFFFF_FFFE, write control=3. irq rises 2 cycles later; writing control=4'b0111 clears irq while the timer keeps counting.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU memory port: word RAM plus an MMIO window, wait states, Mem_ready strobe.
// Define MEM_BUS_TIMER_EN to add the free-running timer at MMIO_BASE+0x8/+0xC.
module mem_bus_responder #(
    parameter int          RAM_WORDS   = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Mem_data,
    output logic        Mem_ready,
    output logic        Addr_err,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);
    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, cur;
    logic [3:0]  wcnt_q;
    logic        go_resp;
    logic [31:0] rdata_q, rd_val;
    logic        err_q, dec_err, wr_commit;
    logic        is_ram, is_led, is_dig, is_tcnt, is_tctl;
    logic [AW-1:0] ram_idx;
    logic [31:0] ram [RAM_WORDS];

    // With zero wait states the commit edge is the latch edge, so decode the live port in IDLE.
    always_comb begin
        cur = req_q;
        if (state_q == IDLE)
            cur = '{addr: Address, wdata: Write_data, rd: MemRead, wr: MemWrite};
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: if (MemRead | MemWrite) begin
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (wcnt_q <= 4'd1) begin
                state_d = RESP;
                go_resp = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ram_idx = cur.addr[AW+1:2];
    assign is_ram  = cur.addr < RAM_BYTES;
    assign is_led  = cur.addr == MMIO_BASE;
    assign is_dig  = cur.addr == MMIO_BASE + 32'h4;
    assign dec_err = (cur.rd & cur.wr) | (|cur.addr[1:0]) |
                     ~(is_ram | is_led | is_dig | is_tcnt | is_tctl);
    assign wr_commit = go_resp & cur.wr & ~dec_err & ~reset;

`ifdef MEM_BUS_TIMER_EN
    logic [31:0] tmr_cnt;
    logic        tmr_en, tmr_ie, irq_q, tmr_wrap;

    assign is_tcnt  = cur.addr == MMIO_BASE + 32'h8;
    assign is_tctl  = cur.addr == MMIO_BASE + 32'hC;
    assign tmr_wrap = tmr_en & (tmr_cnt == 32'hFFFF_FFFF);
    assign irq      = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_cnt <= '0;
            tmr_en  <= 1'b0;
            tmr_ie  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (tmr_en) tmr_cnt <= tmr_cnt + 32'd1;
            if (wr_commit && is_tctl) begin
                tmr_en <= cur.wdata[0];
                tmr_ie <= cur.wdata[1];
            end
            // A wrap in the same cycle as a clear keeps the interrupt pending.
            if (tmr_wrap && tmr_ie)
                irq_q <= 1'b1;
            else if (wr_commit && is_tctl && cur.wdata[2])
                irq_q <= 1'b0;
        end
    end
`else
    assign is_tcnt = 1'b0;
    assign is_tctl = 1'b0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (is_ram)      rd_val = ram[ram_idx];
        else if (is_led) rd_val = {24'b0, leds};
        else if (is_dig) rd_val = {20'b0, digits};
`ifdef MEM_BUS_TIMER_EN
        else if (is_tcnt) rd_val = tmr_cnt;
        else if (is_tctl) rd_val = {30'b0, tmr_ie, tmr_en};
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_commit && is_ram) ram[ram_idx] <= cur.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            leds    <= '0;
            digits  <= '0;
        end else begin
            if (state_q == IDLE) begin
                req_q  <= cur;
                wcnt_q <= 4'(WAIT_STATES);
            end else if (state_q == WAIT) begin
                wcnt_q <= wcnt_q - 4'd1;
            end
            rdata_q <= (go_resp && cur.rd && !dec_err) ? rd_val : '0;
            err_q   <= go_resp & dec_err;
            if (wr_commit && is_led) leds   <= cur.wdata[7:0];
            if (wr_commit && is_dig) digits <= cur.wdata[11:0];
        end
    end

    // Reset in the response cycle suppresses the strobe as well.
    assign Mem_ready = (state_q == RESP) & ~reset;
    assign Mem_data  = reset ? '0 : rdata_q;
    assign Addr_err  = err_q & ~reset;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a behavioural memory-map model.
module tb_mem_bus_responder;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int WS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a_addr, a_wd, a_data, b_addr, b_wd, b_data;
    logic        a_rd, a_wr, a_rdy, a_err, a_irq, b_rd, b_wr, b_rdy, b_err, b_irq;
    logic [7:0]  a_leds, b_leds;
    logic [11:0] a_dig, b_dig;

    mem_bus_responder #(.RAM_WORDS(256), .WAIT_STATES(WS), .MMIO_BASE(BASE)) dut_a (
        .clk(clk), .reset(reset), .Address(a_addr), .Write_data(a_wd),
        .MemRead(a_rd), .MemWrite(a_wr), .Mem_data(a_data), .Mem_ready(a_rdy),
        .Addr_err(a_err), .leds(a_leds), .digits(a_dig), .irq(a_irq));

    mem_bus_responder #(.RAM_WORDS(256), .WAIT_STATES(0), .MMIO_BASE(BASE)) dut_b (
        .clk(clk), .reset(reset), .Address(b_addr), .Write_data(b_wd),
        .MemRead(b_rd), .MemWrite(b_wr), .Mem_data(b_data), .Mem_ready(b_rdy),
        .Addr_err(b_err), .leds(b_leds), .digits(b_dig), .irq(b_irq));

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference memory map
    logic [31:0] ram_m [256];
    bit          known [256];
    logic [7:0]  leds_m;
    logic [11:0] digits_m;

    function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] q,
                                  output logic e, output bit cmp);
        int w;
        q = '0; e = 1'b0; cmp = 1'b1;
        w = int'(a / 4);
        if ((rd && wr) || (a % 4 != 0)) e = 1'b1;
        else if (a < 32'd1024) begin
            if (wr) begin ram_m[w] = d; known[w] = 1'b1; end
            else begin q = ram_m[w]; cmp = known[w]; end
        end else if (a == BASE) begin
            if (wr) leds_m = d[7:0]; else q = {24'b0, leds_m};
        end else if (a == BASE + 4) begin
            if (wr) digits_m = d[11:0]; else q = {20'b0, digits_m};
        end
`ifdef MEM_BUS_TIMER_EN
        else if (a == BASE + 8) cmp = 1'b0;
`endif
        else e = 1'b1;
    endfunction

    // Drive one request and return at the negedge where Mem_ready is seen.
    task automatic bus(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] q, output logic e,
                       output int lat);
        @(negedge clk);
        if (sel) begin b_addr = a; b_wd = d; b_rd = rd; b_wr = wr; end
        else     begin a_addr = a; a_wd = d; a_rd = rd; a_wr = wr; end
        lat = 0; q = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((sel ? b_rdy : a_rdy) === 1'b1) begin
                lat = i;
                q = sel ? b_data : a_data;
                e = sel ? b_err : a_err;
                break;
            end
        end
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        if (lat == 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic do_tx(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q, eq;
        logic        e, ee;
        bit          cmp;
        int          lat;
        model(rd, wr, a, d, eq, ee, cmp);
        bus(1'b0, rd, wr, a, d, q, e, lat);
        chk({tag, ".lat"}, lat, WS + 1);
        chk({tag, ".err"}, {31'b0, e}, {31'b0, ee});
        if ((rd || ee) && cmp) chk({tag, ".data"}, q, eq);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'b0, a_rdy}, 32'd0);
        chk({tag, ".leds"}, {24'b0, a_leds}, {24'b0, leds_m});
        chk({tag, ".digits"}, {20'b0, a_dig}, {20'b0, digits_m});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q, a, d, c1, c2;
        logic        e, rd, wr;
        int          lat, w;
        bit          seen;

        reset = 1'b1;
        a_addr = '0; a_wd = '0; a_rd = 1'b0; a_wr = 1'b0;
        b_addr = '0; b_wd = '0; b_rd = 1'b0; b_wr = 1'b0;
        leds_m = '0; digits_m = '0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.rdy", {31'b0, a_rdy}, 32'd0);
        chk("rst.data", a_data, 32'd0);
        chk("rst.err", {31'b0, a_err}, 32'd0);
        chk("rst.leds", {24'b0, a_leds}, 32'd0);
        chk("rst.digits", {20'b0, a_dig}, 32'd0);
        chk("rst.irq", {31'b0, a_irq}, 32'd0);
        chk("rst.b", {b_data[31:0] | {11'b0, b_rdy, b_err, b_irq, b_leds, b_dig}}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) do_tx("init", 1'b0, 1'b1, 32'(i * 4), $urandom);
        do_tx("init.top", 1'b0, 1'b1, 32'h3FC, $urandom);

        do_tx("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_tx("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
        do_tx("wrled", 1'b0, 1'b1, BASE, 32'h0000_01A5);
        do_tx("rdled", 1'b1, 1'b0, BASE, 32'h0);
        do_tx("wrdig", 1'b0, 1'b1, BASE + 4, 32'hFFFF_F7C3);
        do_tx("rddig", 1'b1, 1'b0, BASE + 4, 32'h0);
        do_tx("misal", 1'b1, 1'b0, 32'h6, 32'h0);
        do_tx("misalwr", 1'b0, 1'b1, 32'hA, 32'h5555_5555);
        do_tx("unmap", 1'b1, 1'b0, BASE + 32'h20, 32'h0);
        do_tx("ramend", 1'b1, 1'b0, 32'h400, 32'h0);
        do_tx("conflict", 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);
        do_tx("rd8", 1'b1, 1'b0, 32'h8, 32'h0);
        do_tx("rdtop", 1'b1, 1'b0, 32'h3FC, 32'h0);
`ifndef MEM_BUS_TIMER_EN
        do_tx("tcnt_off", 1'b1, 1'b0, BASE + 8, 32'h0);
        do_tx("tctl_off", 1'b0, 1'b1, BASE + 32'hC, 32'h3);
`endif

        // Abort a write with reset while it is waiting.
        @(negedge clk);
        a_addr = 32'h20; a_wd = 32'h1234; a_wr = 1'b1;
        @(negedge clk);
        reset = 1'b1; a_wr = 1'b0;
        seen = (a_rdy === 1'b1);
        repeat (2) @(negedge clk) if (a_rdy === 1'b1) seen = 1'b1;
        reset = 1'b0;
        leds_m = '0; digits_m = '0;
        repeat (3) @(negedge clk) if (a_rdy === 1'b1) seen = 1'b1;
        chk("abort.rdy", {31'b0, seen}, 32'd0);
        chk("abort.leds", {24'b0, a_leds}, 32'd0);
        do_tx("abort.rd", 1'b1, 1'b0, 32'h20, 32'h0);

        // Zero-wait-state instance.
        bus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, q, e, lat);
        chk("b.lat", lat, 32'd1);
        chk("b.err", {31'b0, e}, 32'd0);
        @(negedge clk);
        chk("b.pulse", {31'b0, b_rdy}, 32'd0);
        bus(1'b1, 1'b0, 1'b1, 32'h4, 32'h55AA_33CC, q, e, lat);
        chk("b.wlat", lat, 32'd1);
        bus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, q, e, lat);
        chk("b.rdata", q, 32'h55AA_33CC);
        bus(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, q, e, lat);
        chk("b.misal", {q[30:0], e}, 32'd1);

        for (int n = 0; n < 150; n++) begin
            rd = 1'b0; wr = 1'b0; d = $urandom;
            if ($urandom_range(0, 1) == 1) rd = 1'b1; else wr = 1'b1;
            w = ($urandom_range(0, 16) == 16) ? 255 : int'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'(w * 4);
                4: a = 32'(w * 4) + 32'($urandom_range(1, 3));
                5: a = BASE;
                6: a = BASE + 4;
                7: case ($urandom_range(0, 3))
                       0: a = BASE + 32'(16 + 4 * $urandom_range(0, 15));
                       1: a = 32'h400;
                       2: a = 32'hFFFF_FFFC;
                       default: a = BASE - 4;
                   endcase
`ifdef MEM_BUS_TIMER_EN
                8: a = BASE + 8;
`else
                8: a = ($urandom_range(0, 1) == 1) ? BASE + 8 : BASE + 32'hC;
`endif
                default: begin a = 32'(w * 4); rd = 1'b1; wr = 1'b1; end
            endcase
            do_tx("rand", rd, wr, a, d);
        end

`ifdef MEM_BUS_TIMER_EN
        @(negedge clk);
        force dut_a.tmr_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut_a.tmr_cnt;
        bus(1'b0, 1'b0, 1'b1, BASE + 32'hC, 32'h3, q, e, lat);
        chk("tmr.irq0", {31'b0, a_irq}, 32'd0);
        @(negedge clk);
        chk("tmr.irq1", {31'b0, a_irq}, 32'd0);
        @(negedge clk);
        chk("tmr.irq2", {31'b0, a_irq}, 32'd1);
        bus(1'b0, 1'b0, 1'b1, BASE + 32'hC, 32'h7, q, e, lat);
        chk("tmr.clr", {31'b0, a_irq}, 32'd0);
        bus(1'b0, 1'b1, 1'b0, BASE + 32'hC, 32'h0, q, e, lat);
        chk("tmr.ctl", q, 32'h3);
        bus(1'b0, 1'b1, 1'b0, BASE + 8, 32'h0, c1, e, lat);
        bus(1'b0, 1'b1, 1'b0, BASE + 8, 32'h0, c2, e, lat);
        chk("tmr.count", {31'b0, c2 > c1}, 32'd1);
        chk("tmr.irqlow", {31'b0, a_irq}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
